// File: rtl/up_down_count_monitor.sv
// Up/down counter integrity monitor: filters the sampled count for stability,
// classifies accepted changes as +1 / -1 / illegal, and tracks count direction.
module up_down_count_monitor #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned STABLE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 8,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] last_val,
  output logic             dir_valid,
  output logic             dir,
  output logic             step_up,
  output logic             step_dn,
  output logic             dir_chg,
  output logic             step_err,
  output logic             hold,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned SW = $clog2(STABLE_CYC + 1);
  localparam int unsigned IW = $clog2(HOLD_CYC + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC);
  localparam logic [SW-1:0] STAB_PRE = SW'(STABLE_CYC - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(HOLD_CYC);

  typedef enum logic [1:0] {NOREF, IDLE, UP, DOWN} state_t;

  state_t           state, nxt_state;
  logic [WIDTH-1:0] s1, cand, diff;
  logic [SW-1:0]    stab;
  logic [IW-1:0]    idle;
  logic             accept_raw, valid_acc, is_up, is_dn;
  logic             nxt_up, nxt_dn, nxt_chg, nxt_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      cand <= '0;
      stab <= '0;
    end else begin
      s1 <= cnt_in;
      if (s1 != cand) begin
        cand <= s1;
        stab <= SW'(1);
      end else if (stab != STAB_MAX) begin
        stab <= stab + SW'(1);
      end
      if (!en) stab <= '0;
    end
  end

  // The accepted value always equals s1: either s1 == cand, or cand is loaded from s1.
  assign accept_raw = (s1 != cand) ? (STABLE_CYC == 1) : (stab == STAB_PRE);
  assign valid_acc  = en && accept_raw && ((state == NOREF) || (s1 != last_val));
  assign diff       = s1 - last_val;
  assign is_up      = (diff == WIDTH'(1));
  assign is_dn      = (diff == '1);

  always_ff @(posedge clk) begin
    if (rst) state <= NOREF;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    nxt_up    = 1'b0;
    nxt_dn    = 1'b0;
    nxt_chg   = 1'b0;
    nxt_err   = 1'b0;
    if (!en) begin
      nxt_state = NOREF;
    end else if (valid_acc) begin
      case (state)
        NOREF: nxt_state = IDLE;
        IDLE: begin
          if (is_up) begin
            nxt_state = UP;
            nxt_up    = 1'b1;
          end else if (is_dn) begin
            nxt_state = DOWN;
            nxt_dn    = 1'b1;
          end else begin
            nxt_err = 1'b1;
          end
        end
        UP: begin
          if (is_up) begin
            nxt_up = 1'b1;
          end else if (is_dn) begin
            nxt_state = DOWN;
            nxt_dn    = 1'b1;
            nxt_chg   = 1'b1;
          end else begin
            nxt_state = IDLE;
            nxt_err   = 1'b1;
          end
        end
        DOWN: begin
          if (is_dn) begin
            nxt_dn = 1'b1;
          end else if (is_up) begin
            nxt_state = UP;
            nxt_up    = 1'b1;
            nxt_chg   = 1'b1;
          end else begin
            nxt_state = IDLE;
            nxt_err   = 1'b1;
          end
        end
        default: nxt_state = NOREF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_val  <= '0;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      dir_chg   <= 1'b0;
      step_err  <= 1'b0;
      idle      <= '0;
      err_count <= '0;
    end else begin
      step_up  <= nxt_up;
      step_dn  <= nxt_dn;
      dir_chg  <= nxt_chg;
      step_err <= nxt_err;
      if (valid_acc) last_val <= s1;
      if (!en || valid_acc) idle <= '0;
      else if (idle != IDLE_MAX) idle <= idle + IW'(1);
      if (nxt_err && (err_count != '1)) err_count <= err_count + ERR_W'(1);
    end
  end

  assign dir_valid = (state == UP) || (state == DOWN);
  assign dir       = (state == DOWN);
  assign hold      = dir_valid && (idle == IDLE_MAX);

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Directed bench for up_down_count_monitor (WIDTH=4, STABLE_CYC=2, HOLD_CYC=8).
module tb_up_down_count_monitor;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] cnt_in;
  logic [3:0] last_val;
  logic       dir_valid, dir, step_up, step_dn, dir_chg, step_err, hold;
  logic [7:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_up, n_dn, n_chg, n_err, n_hold;

  up_down_count_monitor #(
    .WIDTH(4), .STABLE_CYC(2), .HOLD_CYC(8), .ERR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in),
    .last_val(last_val), .dir_valid(dir_valid), .dir(dir),
    .step_up(step_up), .step_dn(step_dn), .dir_chg(dir_chg),
    .step_err(step_err), .hold(hold), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_up = 0; n_dn = 0; n_chg = 0; n_err = 0; n_hold = 0;
  endtask

  // One clock edge, then sample outputs 1 time unit later and tally pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    n_up   += int'(step_up);
    n_dn   += int'(step_dn);
    n_chg  += int'(dir_chg);
    n_err  += int'(step_err);
    n_hold += int'(hold);
  endtask

  task automatic hold_val(input logic [3:0] v, input int n);
    cnt_in = v;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; cnt_in = 4'd0;
    clear_counts();
    tick(); tick();
    check("rst_last_val", 32'(last_val), 0);
    check("rst_dir_valid", 32'(dir_valid), 0);
    check("rst_pulses", 32'({step_up, step_dn, dir_chg, step_err, hold}), 0);
    check("rst_err_count", 32'(err_count), 0);

    // 1: full up count with wrap
    rst = 1'b0;
    hold_val(4'd0, 4);
    check("t1_noref_last", 32'(last_val), 0);
    check("t1_noref_dirv", 32'(dir_valid), 0);
    check("t1_noref_nopulse", 32'(n_up + n_dn + n_err), 0);
    for (int v = 1; v <= 16; v++) hold_val(4'(v), 4);
    check("t1_step_up_cnt", 32'(n_up), 16);
    check("t1_other_pulses", 32'(n_dn + n_err + n_chg), 0);
    check("t1_dir_valid", 32'(dir_valid), 1);
    check("t1_dir", 32'(dir), 0);
    check("t1_err_count", 32'(err_count), 0);
    check("t1_no_hold", 32'(n_hold), 0);

    // 2: up to 5, reverse down to 2
    clear_counts();
    for (int v = 1; v <= 5; v++) hold_val(4'(v), 4);
    check("t2_up_cnt", 32'(n_up), 5);
    clear_counts();
    hold_val(4'd4, 4);
    check("t2_rev_dn", 32'(n_dn), 1);
    check("t2_rev_chg", 32'(n_chg), 1);
    check("t2_dir", 32'(dir), 1);
    clear_counts();
    hold_val(4'd3, 4);
    hold_val(4'd2, 4);
    check("t2_dn_cnt", 32'(n_dn), 2);
    check("t2_no_chg_err", 32'(n_chg + n_err), 0);

    // 3: glitch filtering
    clear_counts();
    hold_val(4'd3, 4);
    check("t3_rev_up", 32'(n_up), 1);
    check("t3_rev_chg", 32'(n_chg), 1);
    clear_counts();
    hold_val(4'd7, 1);
    hold_val(4'd3, 6);
    check("t3_glitch_nopulse", 32'(n_up + n_dn + n_err + n_chg), 0);
    check("t3_last_val", 32'(last_val), 3);
    check("t3_state", 32'({dir_valid, dir}), 32'b10);

    // 4: illegal jump 6 -> 9, exact pulse timing
    hold_val(4'd4, 4); hold_val(4'd5, 4); hold_val(4'd6, 4);
    cnt_in = 4'd9;
    tick(); check("t4_err_e0", 32'(step_err), 0);
    tick(); check("t4_err_e1", 32'(step_err), 0);
    tick(); check("t4_err_e2", 32'(step_err), 1);
    check("t4_dir_valid", 32'(dir_valid), 0);
    check("t4_err_count", 32'(err_count), 1);
    check("t4_last_val", 32'(last_val), 9);
    tick(); check("t4_err_e3", 32'(step_err), 0);
    clear_counts();
    hold_val(4'd10, 4);
    check("t4_resume_up", 32'(n_up), 1);
    check("t4_resume_state", 32'({dir_valid, dir}), 32'b10);

    // 5: hold timing
    cnt_in = 4'd11;
    tick(); tick(); tick();
    check("t5_accept", 32'(step_up), 1);
    repeat (7) tick();
    check("t5_hold_a7", 32'(hold), 0);
    tick();
    check("t5_hold_a8", 32'(hold), 1);
    repeat (4) tick();
    check("t5_hold_a12", 32'(hold), 1);
    cnt_in = 4'd12;
    tick(); tick();
    check("t5_hold_pre", 32'(hold), 1);
    tick();
    check("t5_clr_step", 32'(step_up), 1);
    check("t5_clr_hold", 32'(hold), 0);

    // 6: reset on an accept edge, then enable gating
    cnt_in = 4'd13;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("t6_rst_pulse", 32'({step_up, step_dn, dir_chg, step_err, hold}), 0);
    check("t6_rst_last", 32'(last_val), 0);
    check("t6_rst_errc", 32'(err_count), 0);
    check("t6_rst_dirv", 32'(dir_valid), 0);
    rst = 1'b0;
    clear_counts();
    hold_val(4'd13, 4);
    check("t6_relearn_nopulse", 32'(n_up + n_dn + n_err), 0);
    check("t6_relearn_last", 32'(last_val), 13);
    hold_val(4'd14, 4);
    check("t6_up_after_rst", 32'(n_up), 1);
    hold_val(4'd2, 4);
    check("t6_err", 32'(n_err), 1);
    check("t6_errc", 32'(err_count), 1);
    hold_val(4'd3, 4);
    check("t6_up_state", 32'({dir_valid, dir}), 32'b10);
    clear_counts();
    en = 1'b0;
    hold_val(4'd4, 5);
    check("t6_en0_pulses", 32'(n_up + n_dn + n_err + n_chg + n_hold), 0);
    check("t6_en0_dirv", 32'(dir_valid), 0);
    check("t6_en0_last", 32'(last_val), 3);
    check("t6_en0_errc", 32'(err_count), 1);
    en = 1'b1;
    tick(); tick();
    check("t6_en1_relearn", 32'(last_val), 4);
    check("t6_en1_nopulse", 32'(n_up + n_dn + n_err), 0);
    check("t6_en1_dirv", 32'(dir_valid), 0);
    hold_val(4'd5, 4);
    check("t6_en1_up", 32'(n_up), 1);
    check("t6_en1_state", 32'({dir_valid, dir}), 32'b10);
    check("t6_en1_errc", 32'(err_count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
